seq_multiplier: RTL

Parametrised iterative shift-add multiplier with valid/ready handshakes on both sides and runtime signed/unsigned mode. It is the sequential, area-lean successor to the combinational multiplier: one partial product per clock, a registered full-width result, and iEn/iClr control matching the rest of the arithmetic library. It sits between an upstream operand producer and a downstream consumer, and can replace the combinational multiplier wherever BITWIDTH-cycle latency is acceptable.

---
 rtl/seq_multiplier.sv | 129 ++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
`timescale 1ns/1ps
// Iterative shift-add multiplier, one partial product per clock, signed/unsigned at runtime.
// Latency BITWIDTH cycles from acceptance; result holds in DONE until downstream takes it.
module seq_multiplier #(
  parameter int BITWIDTH = 32
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iEn,
  input  logic                    iClr,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic [BITWIDTH-1:0]     iData0,
  input  logic [BITWIDTH-1:0]     iData1,
  input  logic                    iSigned,
  output logic                    oValid,
  input  logic                    iReady,
  output logic [2*BITWIDTH-1:0]   oData,
  output logic                    oBusy
);

  localparam int CW = $clog2(BITWIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BITWIDTH-1:0]   mcand_q, mcand_d;
  logic [BITWIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [BITWIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic                  neg_q, neg_d;
  logic [2*BITWIDTH-1:0] data_q, data_d;

  logic                  accept;
  logic                  load;
  logic [BITWIDTH-1:0]   mag0, mag1;
  logic [BITWIDTH:0]     sum;
  logic [2*BITWIDTH-1:0] prod;

  always_comb begin
    oReady = 1'b0;
    if (!iRst) begin
      case (state_q)
        S_IDLE:  oReady = iEn;
        S_DONE:  oReady = iEn & iReady;
        default: oReady = 1'b0;
      endcase
    end
  end

  assign accept = iValid & oReady;
  assign oValid = (state_q == S_DONE);
  assign oBusy  = (state_q == S_CALC);
  assign oData  = data_q;

  // Magnitude of the most negative value wraps to 2^(BITWIDTH-1), which is correct as unsigned.
  assign mag0 = (iSigned && iData0[BITWIDTH-1]) ? -iData0 : iData0;
  assign mag1 = (iSigned && iData1[BITWIDTH-1]) ? -iData1 : iData1;

  assign sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : {(BITWIDTH+1){1'b0}});
  assign prod = {sum, acc_lo_q[BITWIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    neg_d    = neg_q;
    data_d   = data_q;
    load     = 1'b0;

    if (iClr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      data_d  = '0;
    end else if (iEn) begin
      case (state_q)
        S_IDLE: load = accept;
        S_CALC: begin
          acc_hi_d = sum[BITWIDTH:1];
          acc_lo_d = {sum[0], acc_lo_q[BITWIDTH-1:1]};
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            data_d  = neg_q ? -prod : prod;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (iReady) begin
            state_d = S_IDLE;
            load    = accept;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (load) begin
        mcand_d  = mag0;
        acc_lo_d = mag1;
        acc_hi_d = '0;
        neg_d    = iSigned & (iData0[BITWIDTH-1] ^ iData1[BITWIDTH-1]);
        cnt_d    = CW'(BITWIDTH);
        state_d  = S_CALC;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      neg_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      neg_q    <= neg_d;
      data_q   <= data_d;
    end
  end

endmodule
